// File: rtl/decrypt_pipe_if.sv
// Valid/ready bus for the nibble-cipher decryptor: ciphertext+key in, plaintext out.
interface decrypt_pipe_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] enc_in;
  logic [7:0] key_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dec_out;

  modport master (
    output in_valid, enc_in, key_in, out_ready,
    input  in_ready, out_valid, dec_out
  );

  modport slave (
    input  in_valid, enc_in, key_in, out_ready,
    output in_ready, out_valid, dec_out
  );
endinterface

// File: rtl/decrypt_pipe.sv
// Two-stage elastic decryptor for the 8-bit single-round nibble cipher.
// Optional DEC_SELFCHECK_EN re-encrypts each output word and flags mismatches on check_err.
module decrypt_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  decrypt_pipe_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
`ifdef DEC_SELFCHECK_EN
  ,
  output logic             check_err
`endif
);

  // Round function: expand L, mix with key, add halves plus key LSB.
  function automatic logic [3:0] round_f(input logic [3:0] l, input logic [7:0] k);
    logic [7:0] e;
    logic [7:0] x;
    e = {l[3], l[0], l[1], l[2], l[1], l[3], l[2], l[0]};
    x = e ^ k;
    return x[7:4] + x[3:0] + {3'b000, k[0]};
  endfunction

  logic       s1_valid;
  logic [7:0] s1_enc;
  logic [7:0] s1_key;
  logic       advance_c;
  logic       in_fire_c;
  logic       out_fire_c;

  assign advance_c   = s1_valid && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = !s1_valid || advance_c;
  assign in_fire_c   = bus.in_valid && bus.in_ready;
  assign out_fire_c  = bus.out_valid && bus.out_ready;
  assign busy        = s1_valid || bus.out_valid;

  // Stage 1: capture ciphertext and key.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_enc   <= 8'h00;
      s1_key   <= 8'h00;
    end else if (in_fire_c) begin
      s1_valid <= 1'b1;
      s1_enc   <= bus.enc_in;
      s1_key   <= bus.key_in;
    end else if (advance_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: strip the round function off the high nibble and present the plaintext.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.dec_out   <= 8'h00;
    end else if (advance_c) begin
      bus.out_valid <= 1'b1;
      bus.dec_out   <= {s1_enc[7:4] ^ round_f(s1_enc[3:0], s1_key), s1_enc[3:0]};
    end else if (out_fire_c) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Delivered-word counter, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt <= '0;
    end else if (out_fire_c && (word_cnt != {CNT_W{1'b1}})) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

`ifdef DEC_SELFCHECK_EN
  logic [7:0] s2_enc;
  logic [7:0] s2_key;
  logic [7:0] reenc_c;

  assign reenc_c = {bus.dec_out[7:4] ^ round_f(bus.dec_out[3:0], s2_key), bus.dec_out[3:0]};

  // Keep the source ciphertext next to the output word and compare after re-encryption.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_enc    <= 8'h00;
      s2_key    <= 8'h00;
      check_err <= 1'b0;
    end else begin
      if (advance_c) begin
        s2_enc <= s1_enc;
        s2_key <= s1_key;
      end
      if (bus.out_valid && (reenc_c != s2_enc)) begin
        check_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decrypt_pipe.sv
// Self-checking bench for decrypt_pipe: vector table, hand sequences and a random scoreboard run.
module tb_decrypt_pipe;

  logic clock;
  logic reset;
  logic busy;
  logic [15:0] word_cnt;
  logic sat_busy;
  logic [1:0] sat_cnt;
`ifdef DEC_SELFCHECK_EN
  logic check_err;
  logic sat_check_err;
`endif

  decrypt_pipe_if bus();
  decrypt_pipe_if bus_sat();

  assign bus_sat.in_valid  = bus.in_valid;
  assign bus_sat.enc_in    = bus.enc_in;
  assign bus_sat.key_in    = bus.key_in;
  assign bus_sat.out_ready = bus.out_ready;

  decrypt_pipe #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave), .busy(busy), .word_cnt(word_cnt)
`ifdef DEC_SELFCHECK_EN
    , .check_err(check_err)
`endif
  );

  decrypt_pipe #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .bus(bus_sat.slave), .busy(sat_busy), .word_cnt(sat_cnt)
`ifdef DEC_SELFCHECK_EN
    , .check_err(sat_check_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] enc;
    logic [7:0] key;
    logic [7:0] dec;
  } vec_t;

  typedef struct {
    logic [7:0] dec;
    int         avail;
  } flight_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_cnt = 0;
  logic [7:0] last_out = 8'h00;
  bit last_acc = 1'b0;
  flight_t q[$];
  vec_t tbl[5];

  // Plaintext from the cipher definition, using plain integer arithmetic.
  function automatic logic [7:0] ref_dec(input logic [7:0] c, input logic [7:0] k);
    int l, e, x, f, h;
    l = int'(c) & 15;
    h = int'(c) >> 4;
    e = (((l >> 3) & 1) << 7) | ((l & 1) << 6) | (((l >> 1) & 1) << 5) | (((l >> 2) & 1) << 4)
      | (((l >> 1) & 1) << 3) | (((l >> 3) & 1) << 2) | (((l >> 2) & 1) << 1) | (l & 1);
    x = e ^ int'(k);
    f = ((x >> 4) + (x & 15) + (int'(k) & 1)) % 16;
    return 8'(((h ^ f) << 4) | l);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check against the in-flight model, then advance the model.
  task automatic step(input logic iv, input logic [7:0] e, input logic [7:0] k, input logic ordy);
    bit exp_rdy, exp_ov, inf, outf;
    logic [7:0] exp_dec;
    flight_t w;
    bus.in_valid  = iv;
    bus.enc_in    = e;
    bus.key_in    = k;
    bus.out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    exp_ov  = (q.size() > 0) && (cyc >= q[0].avail);
    exp_dec = exp_ov ? q[0].dec : last_out;
    chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
    chk("out_valid", int'(bus.out_valid), int'(exp_ov));
    chk("dec_out", int'(bus.dec_out), int'(exp_dec));
    chk("busy", int'(busy), int'(q.size() > 0));
    chk("word_cnt", int'(word_cnt), exp_cnt);
    chk("word_cnt_sat", int'(sat_cnt), (exp_cnt > 3) ? 3 : exp_cnt);
`ifdef DEC_SELFCHECK_EN
    chk("check_err", int'(check_err), 0);
`endif
    inf  = iv && exp_rdy;
    outf = exp_ov && ordy;
    @(posedge clock);
    if (outf) begin
      last_out = q[0].dec;
      void'(q.pop_front());
      if (exp_cnt < 65535) exp_cnt++;
      if (q.size() > 0 && q[0].avail < cyc + 1) q[0].avail = cyc + 1;
    end
    if (inf) begin
      w.dec   = ref_dec(e, k);
      w.avail = cyc + 2;
      q.push_back(w);
    end
    last_acc = inf;
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    exp_cnt  = 0;
    last_out = 8'h00;
    cyc++;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_word_cnt", int'(word_cnt), 0);
    chk("rst_dec_out", int'(bus.dec_out), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
  endtask

  initial begin
    int idx;
    logic iv;
    logic [7:0] e, k;
    logic [7:0] flip;

    tbl[0] = '{enc: 8'h06, key: 8'h93, dec: 8'h46};
    tbl[1] = '{enc: 8'h39, key: 8'hAC, dec: 8'hC9};
    tbl[2] = '{enc: 8'h35, key: 8'h5A, dec: 8'hA5};
    tbl[3] = '{enc: 8'h00, key: 8'h00, dec: 8'h00};
    tbl[4] = '{enc: 8'hFF, key: 8'hFF, dec: 8'hEF};

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.enc_in = 8'h00;
    bus.key_in = 8'h00;
    bus.out_ready = 1'b0;
    do_reset();

    // Single words: out_valid low one cycle after acceptance, plaintext exactly two cycles after.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, tbl[i].enc, tbl[i].key, 1'b1);
      #1;
      chk("lat_t1_out_valid", int'(bus.out_valid), 0);
      step(1'b0, 8'h00, 8'h00, 1'b1);
      #1;
      chk("lat_t2_out_valid", int'(bus.out_valid), 1);
      chk("vec_dec", int'(bus.dec_out), int'(tbl[i].dec));
      step(1'b0, 8'h00, 8'h00, 1'b1);
    end

    // Back-to-back stream at full throughput.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, tbl[i].enc, tbl[i].key, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("stream_word_cnt", int'(word_cnt), 3);

    // Stall with out_ready low for 5 cycles while streaming, then release.
    do_reset();
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, tbl[idx].enc, tbl[idx].key, 1'b0);
      if (last_acc) idx++;
    end
    chk("stall_accepted", idx, 2);
    #1;
    chk("stall_dec_hold", int'(bus.dec_out), 8'h46);
    chk("stall_in_ready", int'(bus.in_ready), 0);
    for (int c = 0; c < 8; c++) begin
      step(idx < 3, tbl[idx < 3 ? idx : 0].enc, tbl[idx < 3 ? idx : 0].key, 1'b1);
      if (last_acc) idx++;
    end
    chk("stall_word_cnt", int'(word_cnt), 3);

    // Reset with two words in flight, then a fresh word.
    step(1'b1, tbl[0].enc, tbl[0].key, 1'b0);
    step(1'b1, tbl[1].enc, tbl[1].key, 1'b0);
    do_reset();
    step(1'b1, tbl[2].enc, tbl[2].key, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    #1;
    chk("post_rst_dec", int'(bus.dec_out), 8'hA5);
    step(1'b0, 8'h00, 8'h00, 1'b1);

    // Narrow counter saturates at 3.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, tbl[i].enc, tbl[i].key, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("sat_cnt_final", int'(sat_cnt), 3);
    chk("wide_cnt_final", int'(word_cnt), 5);

    // Random traffic against the scoreboard; inputs held while stalled.
    do_reset();
    iv = 1'b0;
    e = 8'h00;
    k = 8'h00;
    idx = 0;
    while (idx < 1000 && cyc < 20000) begin
      if (!(iv && !last_acc)) begin
        iv = ($urandom_range(0, 3) != 0);
        e  = 8'($urandom);
        k  = 8'($urandom);
      end
      step(iv, e, k, $urandom_range(0, 3) != 0);
      if (last_acc) idx++;
    end
    chk("rand_accepted", idx, 1000);
    for (int c = 0; c < 50 && q.size() > 0; c++) step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("rand_drained", int'(q.size()), 0);
    chk("rand_word_cnt", int'(word_cnt), exp_cnt);

`ifdef DEC_SELFCHECK_EN
    // Corrupt the held output word and expect a sticky error until reset.
    do_reset();
    step(1'b1, tbl[0].enc, tbl[0].key, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    flip = bus.dec_out ^ 8'h10;
    force bus.dec_out = flip;
    @(posedge clock);
    @(negedge clock);
    release bus.dec_out;
    #1;
    chk("selfcheck_set", int'(check_err), 1);
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("selfcheck_sticky", int'(check_err), 1);
    do_reset();
    chk("selfcheck_cleared", int'(check_err), 0);
`else
    flip = 8'h00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
